// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL reset/lock supervisor.
package pll_sup_pkg;

   typedef enum logic [2:0] {
      S_RST,
      S_WAIT,
      S_STAB,
      S_LOCK,
      S_FAIL
   } chan_state_e;

   localparam int LOSS_W = 8;

   // Bits needed to hold the values 0..max_val inclusive.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/pll_sup_chan.sv
// One supervised PLL: lock synchroniser, relock FSM with timeout/retry,
// and a saturating lock-loss counter. All outputs come straight from flops.
module pll_sup_chan
   import pll_sup_pkg::*;
#(
   parameter int RST_PULSE_CYC    = 16,
   parameter int LOCK_STABLE_CYC  = 1024,
   parameter int LOCK_TIMEOUT_CYC = 65536,
   parameter int MAX_RETRY        = 3
) (
   input  logic              clkin1,
   input  logic              rst,
   input  logic              pll_lock,
   input  logic              clr_fail,
   output logic              pll_rst,
   output logic              domain_rst,
   output logic              locked,
   output logic              fail,
   output logic [LOSS_W-1:0] loss_cnt
);

   localparam int PW = cnt_width(RST_PULSE_CYC);
   localparam int SW = cnt_width(LOCK_STABLE_CYC);
   localparam int TW = cnt_width(LOCK_TIMEOUT_CYC);
   localparam int RW = cnt_width(MAX_RETRY);

   localparam logic [PW-1:0] P_LAST = PW'(RST_PULSE_CYC - 1);
   localparam logic [SW-1:0] S_DONE = SW'(LOCK_STABLE_CYC);
   localparam logic [TW-1:0] T_DONE = TW'(LOCK_TIMEOUT_CYC);
   localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

   logic [1:0]        sync_q;
   logic              lock_s;
   chan_state_e       state_q, state_d;
   logic [PW-1:0]     pcnt_q, pcnt_d;
   logic [SW-1:0]     scnt_q, scnt_d;
   logic [TW-1:0]     tcnt_q, tcnt_d, tcnt_inc;
   logic [RW-1:0]     rcnt_q, rcnt_d, rcnt_inc;
   logic [LOSS_W-1:0] loss_q, loss_d;
   logic              timeout;
   logic              pll_rst_q, domain_rst_q, locked_q, fail_q;

   assign lock_s = sync_q[1];

   // NOTE: sequential state is only ever written with non-blocking assignments.
   always_ff @(posedge clkin1) begin
      if (rst) begin
         sync_q       <= '0;
         state_q      <= S_RST;
         pcnt_q       <= '0;
         scnt_q       <= '0;
         tcnt_q       <= '0;
         rcnt_q       <= '0;
         loss_q       <= '0;
         pll_rst_q    <= 1'b1;
         domain_rst_q <= 1'b1;
         locked_q     <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         sync_q       <= {sync_q[0], pll_lock};
         state_q      <= state_d;
         pcnt_q       <= pcnt_d;
         scnt_q       <= scnt_d;
         tcnt_q       <= tcnt_d;
         rcnt_q       <= rcnt_d;
         loss_q       <= loss_d;
         pll_rst_q    <= (state_d == S_RST) || (state_d == S_FAIL);
         domain_rst_q <= (state_d != S_LOCK);
         locked_q     <= (state_d == S_LOCK);
         fail_q       <= (state_d == S_FAIL);
      end
   end

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      pcnt_d   = pcnt_q;
      scnt_d   = scnt_q;
      tcnt_d   = tcnt_q;
      rcnt_d   = rcnt_q;
      loss_d   = loss_q;
      tcnt_inc = tcnt_q + 1'b1;
      rcnt_inc = rcnt_q + 1'b1;
      timeout  = (tcnt_inc == T_DONE);

      unique case (state_q)
         S_RST: begin
            tcnt_d = '0;
            if (pcnt_q == P_LAST) begin
               state_d = S_WAIT;
               pcnt_d  = '0;
            end else begin
               pcnt_d = pcnt_q + 1'b1;
            end
         end
         S_WAIT, S_STAB: begin
            tcnt_d = tcnt_inc;
            // A timeout outranks both lock arrival and stable completion.
            if (timeout) begin
               tcnt_d  = '0;
               rcnt_d  = rcnt_inc;
               state_d = (rcnt_inc == R_MAX) ? S_FAIL : S_RST;
            end else if (state_q == S_WAIT) begin
               if (lock_s) begin
                  state_d = S_STAB;
                  scnt_d  = '0;
               end
            end else if (!lock_s) begin
               state_d = S_WAIT;
               scnt_d  = '0;
            end else if (scnt_q == S_DONE) begin
               state_d = S_LOCK;
               rcnt_d  = '0;
            end else begin
               scnt_d = scnt_q + 1'b1;
            end
         end
         S_LOCK: begin
            if (!lock_s) begin
               state_d = S_RST;
               loss_d  = (loss_q == '1) ? loss_q : loss_q + 1'b1;
            end
         end
         S_FAIL: begin
            if (clr_fail) begin
               state_d = S_RST;
               rcnt_d  = '0;
            end
         end
         default: state_d = S_RST;
      endcase
   end

   assign pll_rst    = pll_rst_q;
   assign domain_rst = domain_rst_q;
   assign locked     = locked_q;
   assign fail       = fail_q;
   assign loss_cnt   = loss_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Reset and lock supervisor for N_PLL independent PLLs running on the
// free-running reference clock; one pll_sup_chan per PLL.
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int N_PLL            = 2,
   parameter int RST_PULSE_CYC    = 16,
   parameter int LOCK_STABLE_CYC  = 1024,
   parameter int LOCK_TIMEOUT_CYC = 65536,
   parameter int MAX_RETRY        = 3
) (
   input  logic                      clkin1,
   input  logic                      rst,
   input  logic [N_PLL-1:0]          pll_lock,
   input  logic [N_PLL-1:0]          clr_fail,
   output logic [N_PLL-1:0]          pll_rst,
   output logic [N_PLL-1:0]          domain_rst,
   output logic [N_PLL-1:0]          locked,
   output logic                      all_locked,
   output logic [N_PLL-1:0]          fail,
   output logic [LOSS_W*N_PLL-1:0]   loss_cnt
);

   for (genvar g = 0; g < N_PLL; g++) begin : g_chan
      pll_sup_chan #(
         .RST_PULSE_CYC   (RST_PULSE_CYC),
         .LOCK_STABLE_CYC (LOCK_STABLE_CYC),
         .LOCK_TIMEOUT_CYC(LOCK_TIMEOUT_CYC),
         .MAX_RETRY       (MAX_RETRY)
      ) u_chan (
         .clkin1    (clkin1),
         .rst       (rst),
         .pll_lock  (pll_lock[g]),
         .clr_fail  (clr_fail[g]),
         .pll_rst   (pll_rst[g]),
         .domain_rst(domain_rst[g]),
         .locked    (locked[g]),
         .fail      (fail[g]),
         .loss_cnt  (loss_cnt[LOSS_W*g +: LOSS_W])
      );
   end

   // Each locked bit is a flop, so this AND adds no input-to-output path.
   assign all_locked = &locked;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scenario-driven bench for pll_lock_supervisor, compared each cycle against a
// timestamp-based reference model plus targeted latency/boundary checks.
module tb_pll_lock_supervisor;

   localparam int N   = 2;
   localparam int RPC = 4;
   localparam int LSC = 8;
   localparam int LTC = 64;
   localparam int MR  = 3;
   localparam int OW  = 12 * N + 1;
   localparam logic [OW-1:0] RESET_VEC =
      {{N{1'b1}}, {N{1'b1}}, {N{1'b0}}, 1'b0, {N{1'b0}}, {8*N{1'b0}}};

   logic           clkin1 = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   pll_lock = '0;
   logic [N-1:0]   clr_fail = '0;
   logic [N-1:0]   pll_rst, domain_rst, locked, fail;
   logic           all_locked;
   logic [8*N-1:0] loss_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clkin1 = ~clkin1;

   pll_lock_supervisor #(
      .N_PLL(N), .RST_PULSE_CYC(RPC), .LOCK_STABLE_CYC(LSC),
      .LOCK_TIMEOUT_CYC(LTC), .MAX_RETRY(MR)
   ) dut (
      .clkin1(clkin1), .rst(rst), .pll_lock(pll_lock), .clr_fail(clr_fail),
      .pll_rst(pll_rst), .domain_rst(domain_rst), .locked(locked),
      .all_locked(all_locked), .fail(fail), .loss_cnt(loss_cnt)
   );

   wire [OW-1:0] obs = {pll_rst, domain_rst, locked, all_locked, fail, loss_cnt};

   // Reference model: each channel remembers when its current phase began
   // and derives every transition from elapsed edge counts.
   typedef enum {M_RST, M_WAIT, M_STAB, M_LOCK, M_FAIL} mph_e;
   mph_e        ph [N];
   int          cyc = 0;
   int          t_entry [N], t_rel [N], t_stab [N], tries [N], losses [N];
   bit          h1 [N], h2 [N];
   bit          l_s;
   logic [N-1:0]   e_pr, e_dr, e_lk, e_fl;
   logic [8*N-1:0] e_loss;
   logic [OW-1:0]  exp_vec;

   always @(posedge clkin1) begin
      cyc++;
      for (int i = 0; i < N; i++) begin
         l_s   = h2[i];
         h2[i] = h1[i];
         h1[i] = pll_lock[i];
         if (rst) begin
            ph[i] = M_RST; t_entry[i] = cyc; tries[i] = 0; losses[i] = 0;
            h1[i] = 1'b0; h2[i] = 1'b0;
         end else begin
            case (ph[i])
               M_RST: if (cyc - t_entry[i] == RPC) begin ph[i] = M_WAIT; t_rel[i] = cyc; end
               M_WAIT, M_STAB: begin
                  if (cyc - t_rel[i] == LTC) begin
                     tries[i]++;
                     if (tries[i] == MR) ph[i] = M_FAIL;
                     else begin ph[i] = M_RST; t_entry[i] = cyc; end
                  end else if (ph[i] == M_WAIT) begin
                     if (l_s) begin ph[i] = M_STAB; t_stab[i] = cyc; end
                  end else if (!l_s) begin
                     ph[i] = M_WAIT;
                  end else if (cyc - t_stab[i] == LSC + 1) begin
                     ph[i] = M_LOCK; tries[i] = 0;
                  end
               end
               M_LOCK: if (!l_s) begin
                  ph[i] = M_RST; t_entry[i] = cyc;
                  if (losses[i] < 255) losses[i]++;
               end
               M_FAIL: if (clr_fail[i]) begin ph[i] = M_RST; t_entry[i] = cyc; tries[i] = 0; end
               default: ;
            endcase
         end
         e_pr[i] = (ph[i] == M_RST) || (ph[i] == M_FAIL);
         e_dr[i] = (ph[i] != M_LOCK);
         e_lk[i] = (ph[i] == M_LOCK);
         e_fl[i] = (ph[i] == M_FAIL);
         e_loss[8*i +: 8] = 8'(losses[i]);
      end
      exp_vec = {e_pr, e_dr, e_lk, &e_lk, e_fl, e_loss};
   end

   task automatic step();
      @(posedge clkin1);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; pll_lock = '0; clr_fail = '0;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      n_cmp++; if (pll_rst !== 2'b11) begin n_bad++; $display("FAIL reset_pll_rst got %b want 11", pll_rst); end
      n_cmp++; if (domain_rst !== 2'b11) begin n_bad++; $display("FAIL reset_domain_rst got %b want 11", domain_rst); end
      n_cmp++; if ({locked, all_locked} !== 3'b000) begin n_bad++; $display("FAIL reset_locked got %b want 000", {locked, all_locked}); end
      n_cmp++; if (fail !== 2'b00) begin n_bad++; $display("FAIL reset_fail got %b want 00", fail); end
      n_cmp++; if (loss_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_loss got %h want 0000", loss_cnt); end
      n_cmp++; if (obs !== exp_vec) begin n_bad++; $display("FAIL reset_model got %h want %h", obs, exp_vec); end
      rst = 1'b0;
   endtask

   task automatic test_clean_lock();
      int width, k;
      bit done;
      do_reset();
      width = 1; done = 0;
      for (int j = 0; j < 20 && !done; j++) begin
         step();
         n_cmp++; if (obs !== exp_vec) begin n_bad++; $display("FAIL clean_model t=%0t got %h want %h", $time, obs, exp_vec); end
         if (pll_rst[0]) width++; else done = 1;
      end
      n_cmp++; if (width != RPC) begin n_bad++; $display("FAIL clean_pulse_width got %0d want %0d", width, RPC); end
      repeat (10) begin
         step();
         n_cmp++; if (obs !== exp_vec) begin n_bad++; $display("FAIL clean_model t=%0t got %h want %h", $time, obs, exp_vec); end
      end
      // The rise is sampled on the first edge after this drive; locked follows LSC+3 edges later.
      pll_lock[0] = 1'b1;
      k = 0;
      while (k < 40) begin
         step(); k++;
         n_cmp++; if (obs !== exp_vec) begin n_bad++; $display("FAIL clean_model t=%0t got %h want %h", $time, obs, exp_vec); end
         if (locked[0]) break;
      end
      n_cmp++; if (k != LSC + 4) begin n_bad++; $display("FAIL clean_lock_latency got %0d edges want %0d", k, LSC + 4); end
      n_cmp++; if (all_locked !== 1'b0) begin n_bad++; $display("FAIL clean_all_locked_early got %b want 0", all_locked); end
      pll_lock[1] = 1'b1;
      k = 0;
      while (k < 40 && locked[1] !== 1'b1) begin
         step(); k++;
         n_cmp++; if (obs !== exp_vec) begin n_bad++; $display("FAIL clean_model t=%0t got %h want %h", $time, obs, exp_vec); end
      end
      n_cmp++; if ({locked, all_locked} !== 3'b111) begin n_bad++; $display("FAIL clean_all_locked got %b want 111", {locked, all_locked}); end
   endtask

   task automatic test_chatter();
      int rel_k, rise_k, fall2_k;
      bit seen_lock;
      do_reset();
      rel_k = -1; rise_k = -1; fall2_k = -1; seen_lock = 0;
      for (int k = 1; k <= 100; k++) begin
         step();
         n_cmp++; if (obs !== exp_vec) begin n_bad++; $display("FAIL chatter_model t=%0t got %h want %h", $time, obs, exp_vec); end
         seen_lock |= locked[0];
         if (rel_k < 0) begin if (!pll_rst[0]) rel_k = k; end
         else if (rise_k < 0) begin if (pll_rst[0]) rise_k = k; end
         else if (fall2_k < 0) begin if (!pll_rst[0]) fall2_k = k; end
         if (k % 5 == 0) pll_lock[0] = ~pll_lock[0];
      end
      n_cmp++; if (seen_lock) begin n_bad++; $display("FAIL chatter_locked got 1 want 0"); end
      n_cmp++; if (rise_k - rel_k != LTC) begin n_bad++; $display("FAIL chatter_timeout got %0d want %0d", rise_k - rel_k, LTC); end
      n_cmp++; if (fall2_k - rise_k != RPC) begin n_bad++; $display("FAIL chatter_repulse got %0d want %0d", fall2_k - rise_k, RPC); end
   endtask

   task automatic test_fail_clear();
      int rises, width, k;
      bit prev;
      do_reset();
      pll_lock = 2'b01;
      rises = 0; prev = 1'b1; k = 0;
      while (k < 400 && fail[1] !== 1'b1) begin
         step(); k++;
         n_cmp++; if (obs !== exp_vec) begin n_bad++; $display("FAIL fail_model t=%0t got %h want %h", $time, obs, exp_vec); end
         if (pll_rst[1] && !prev) rises++;
         prev = pll_rst[1];
      end
      n_cmp++; if (rises != MR) begin n_bad++; $display("FAIL fail_attempts got %0d want %0d", rises, MR); end
      n_cmp++; if ({fail[1], pll_rst[1], domain_rst[1]} !== 3'b111) begin n_bad++; $display("FAIL fail_outputs got %b want 111", {fail[1], pll_rst[1], domain_rst[1]}); end
      for (int j = 0; j < 20; j++) begin
         clr_fail = (j == 5) ? 2'b01 : 2'b00;
         step();
         n_cmp++; if (obs !== exp_vec) begin n_bad++; $display("FAIL fail_model t=%0t got %h want %h", $time, obs, exp_vec); end
      end
      n_cmp++; if ({locked[0], fail[0], fail[1]} !== 3'b101) begin n_bad++; $display("FAIL fail_isolation got %b want 101", {locked[0], fail[0], fail[1]}); end
      clr_fail = 2'b10;
      step();
      clr_fail = 2'b00;
      n_cmp++; if ({fail[1], pll_rst[1]} !== 2'b01) begin n_bad++; $display("FAIL fail_clear got %b want 01", {fail[1], pll_rst[1]}); end
      width = 1; k = 0;
      while (k < 20 && pll_rst[1] === 1'b1) begin
         step(); k++;
         n_cmp++; if (obs !== exp_vec) begin n_bad++; $display("FAIL fail_model t=%0t got %h want %h", $time, obs, exp_vec); end
         if (pll_rst[1]) width++;
      end
      n_cmp++; if (width != RPC) begin n_bad++; $display("FAIL fail_restart_pulse got %0d want %0d", width, RPC); end
   endtask

   task automatic test_loss_sat();
      int k;
      bit ok;
      do_reset();
      pll_lock = 2'b01;
      k = 0;
      while (k < 40 && locked[0] !== 1'b1) begin
         step(); k++;
         n_cmp++; if (obs !== exp_vec) begin n_bad++; $display("FAIL loss_model t=%0t got %h want %h", $time, obs, exp_vec); end
      end
      // Lock loss must win over a simultaneous clr_fail.
      clr_fail = 2'b01;
      pll_lock[0] = 1'b0;
      k = 0;
      while (k < 10) begin
         step(); k++;
         n_cmp++; if (obs !== exp_vec) begin n_bad++; $display("FAIL loss_model t=%0t got %h want %h", $time, obs, exp_vec); end
         if (!locked[0]) break;
      end
      clr_fail = 2'b00;
      n_cmp++; if (k != 3) begin n_bad++; $display("FAIL loss_latency got %0d want 3", k); end
      n_cmp++; if ({pll_rst[0], domain_rst[0], fail[0]} !== 3'b110) begin n_bad++; $display("FAIL loss_outputs got %b want 110", {pll_rst[0], domain_rst[0], fail[0]}); end
      n_cmp++; if (loss_cnt[7:0] !== 8'd1) begin n_bad++; $display("FAIL loss_count got %0d want 1", loss_cnt[7:0]); end
      for (int rep = 1; rep < 300; rep++) begin
         pll_lock[0] = 1'b1;
         ok = 0;
         for (int j = 0; j < 40 && !ok; j++) begin
            step();
            n_cmp++; if (obs !== exp_vec) begin n_bad++; $display("FAIL loss_model t=%0t got %h want %h", $time, obs, exp_vec); end
            ok = locked[0];
         end
         pll_lock[0] = 1'b0;
         for (int j = 0; j < 10 && ok; j++) begin
            step();
            n_cmp++; if (obs !== exp_vec) begin n_bad++; $display("FAIL loss_model t=%0t got %h want %h", $time, obs, exp_vec); end
            if (!locked[0]) break;
         end
         if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL loss_relock_timeout rep %0d got locked=0 want 1", rep);
            break;
         end
      end
      n_cmp++; if (loss_cnt !== 16'h00FF) begin n_bad++; $display("FAIL loss_saturate got %h want 00ff", loss_cnt); end
   endtask

   task automatic test_simultaneous();
      int k;
      do_reset();
      k = 0;
      while (k < 10 && pll_rst[0] === 1'b1) begin step(); k++; end
      repeat (52) begin
         step();
         n_cmp++; if (obs !== exp_vec) begin n_bad++; $display("FAIL simul_model t=%0t got %h want %h", $time, obs, exp_vec); end
      end
      // Stable completion now lands on the same edge as the timeout.
      pll_lock[0] = 1'b1;
      repeat (11) step();
      n_cmp++; if ({locked[0], pll_rst[0]} !== 2'b00) begin n_bad++; $display("FAIL simul_pre got %b want 00", {locked[0], pll_rst[0]}); end
      step();
      n_cmp++; if ({locked[0], pll_rst[0], domain_rst[0]} !== 3'b011) begin n_bad++; $display("FAIL simul_timeout_wins got %b want 011", {locked[0], pll_rst[0], domain_rst[0]}); end
      n_cmp++; if (obs !== exp_vec) begin n_bad++; $display("FAIL simul_model t=%0t got %h want %h", $time, obs, exp_vec); end

      do_reset();
      pll_lock = 2'b11;
      k = 0;
      while (k < 10 && pll_rst[0] === 1'b1) begin step(); k++; end
      repeat (3) step();
      n_cmp++; if ({locked[0], pll_rst[0]} !== 2'b00) begin n_bad++; $display("FAIL stab_pre got %b want 00", {locked[0], pll_rst[0]}); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++; if (obs !== RESET_VEC) begin n_bad++; $display("FAIL rst_in_stab got %h want %h", obs, RESET_VEC); end

      pll_lock = 2'b00;
      k = 0;
      while (k < 400 && fail[1] !== 1'b1) begin
         step(); k++;
         n_cmp++; if (obs !== exp_vec) begin n_bad++; $display("FAIL simul_model t=%0t got %h want %h", $time, obs, exp_vec); end
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++; if (obs !== RESET_VEC) begin n_bad++; $display("FAIL rst_in_fail got %h want %h", obs, RESET_VEC); end
   endtask

   task automatic test_random();
      int hold [N];
      do_reset();
      for (int i = 0; i < N; i++) hold[i] = 0;
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (hold[i] == 0) begin
               pll_lock[i] = ($urandom_range(0, 3) != 0);
               hold[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 250) : $urandom_range(1, 30);
            end else begin
               hold[i]--;
            end
            clr_fail[i] = ($urandom_range(0, 15) == 0);
         end
         rst = ($urandom_range(0, 999) == 0);
         step();
         n_cmp++; if (obs !== exp_vec) begin n_bad++; $display("FAIL random_model t=%0t got %h want %h", $time, obs, exp_vec); end
      end
      rst = 1'b0; clr_fail = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_clean_lock();
      test_chatter();
      test_fail_clear();
      test_loss_sat();
      test_simultaneous();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
